// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// Host-side UART receiver. Deserialises an 8-bit, LSB-first frame with
// optional parity and one stop bit, sampled with 16x oversampling, and pushes
// good bytes into a small first-word-fall-through FIFO.
//
// Ports:
//   clk        - system clock
//   rst        - asynchronous active-high reset
//   rx         - serial line (asynchronous, idle high)
//   rd_en      - pop the FIFO head (ignored while empty)
//   err_clr    - clear all sticky error flags (a coinciding error still sets)
//   rx_data    - current FIFO head, valid while rx_empty is low
//   rx_empty   - FIFO empty
//   rx_full    - FIFO full
//   frame_err  - sticky: stop bit sampled low
//   parity_err - sticky: parity mismatch
//   overrun    - sticky: good byte arrived while the FIFO was full
// -----------------------------------------------------------------------------
module uart_rx #(
    parameter int SYS_CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE      = 115200,
    parameter int PARITY_MODE    = 0,
    parameter int FIFO_ADDR_BITS = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       rd_en,
    input  logic       err_clr,
    output logic [7:0] rx_data,
    output logic       rx_empty,
    output logic       rx_full,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overrun
);

    localparam int CLKS_PER_TICK = SYS_CLK_FREQ / (BAUD_RATE * 16);
    localparam int CNT_W         = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam int DEPTH         = 1 << FIFO_ADDR_BITS;
    localparam logic [CNT_W-1:0]        CNT_MAX  = CNT_W'(CLKS_PER_TICK - 1);
    localparam logic [FIFO_ADDR_BITS:0] DEPTH_CT = (FIFO_ADDR_BITS + 1)'(DEPTH);

    if (CLKS_PER_TICK < 1) begin : g_bad_cfg
        $error("uart_rx: SYS_CLK_FREQ / (BAUD_RATE*16) must be at least 1");
    end

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                    state_q, state_d;
    logic                      sync1_q, rx_s_q, rx_prev_q;
    logic [2:0]                warm_q;
    logic [CNT_W-1:0]          clk_cnt_q, clk_cnt_d;
    logic [3:0]                tick_idx_q, tick_idx_d;
    logic [2:0]                bit_cnt_q, bit_cnt_d;
    logic [7:0]                shift_q, shift_d;
    logic                      par_bad_q, par_bad_d;
    logic [7:0]                mem_q [DEPTH];
    logic [FIFO_ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [FIFO_ADDR_BITS:0]   count_q, count_d;
    logic                      frame_err_q, frame_err_d;
    logic                      parity_err_q, parity_err_d;
    logic                      overrun_q, overrun_d;

    logic tick, fall, stop_sample, good, push, pop, full, empty;

    // warm_q fills with ones after reset so that edge detection only starts
    // once the synchroniser and the previous-value flop hold real line data;
    // a line that is already low at reset release is then not seen as a start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
            warm_q    <= 3'b000;
        end else begin
            sync1_q   <= rx;
            rx_s_q    <= sync1_q;
            rx_prev_q <= rx_s_q;
            warm_q    <= {warm_q[1:0], 1'b1};
        end
    end

    assign fall = warm_q[2] & rx_prev_q & ~rx_s_q;
    assign tick = (state_q != IDLE) && (clk_cnt_q == CNT_MAX);

    // Receive FSM. tick_idx counts oversampling ticks within the current bit;
    // START samples at tick 7, later bits sample every 16 ticks from there.
    always_comb begin
        state_d     = state_q;
        clk_cnt_d   = (state_q == IDLE || tick) ? '0 : clk_cnt_q + 1'b1;
        tick_idx_d  = tick ? tick_idx_q + 4'd1 : tick_idx_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        par_bad_d   = par_bad_q;
        stop_sample = 1'b0;
        case (state_q)
            IDLE: begin
                tick_idx_d = 4'd0;
                bit_cnt_d  = 3'd0;
                par_bad_d  = 1'b0;
                if (fall) state_d = START;
            end
            START: begin
                if (tick && tick_idx_q == 4'd7) begin
                    tick_idx_d = 4'd0;
                    state_d    = rx_s_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (tick && tick_idx_q == 4'd15) begin
                    shift_d   = {rx_s_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = (PARITY_MODE != 0) ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (tick && tick_idx_q == 4'd15) begin
                    if (PARITY_MODE == 1) par_bad_d = ~(^shift_q ^ rx_s_q);
                    else                  par_bad_d = ^shift_q ^ rx_s_q;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (tick && tick_idx_q == 4'd15) begin
                    stop_sample = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            clk_cnt_q  <= '0;
            tick_idx_q <= 4'd0;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'd0;
            par_bad_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            clk_cnt_q  <= clk_cnt_d;
            tick_idx_q <= tick_idx_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_bad_q  <= par_bad_d;
        end
    end

    // FIFO and sticky flags. A push into a full FIFO is still accepted when a
    // pop happens on the same edge, so only a full FIFO without a pop overruns.
    assign full  = (count_q == DEPTH_CT);
    assign empty = (count_q == '0);
    assign good  = stop_sample & rx_s_q & ~par_bad_q;
    assign pop   = rd_en & ~empty;
    assign push  = good & (~full | pop);

    always_comb begin
        rd_ptr_d     = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        wr_ptr_d     = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        count_d      = count_q;
        if (push && !pop) count_d = count_q + 1'b1;
        if (pop && !push) count_d = count_q - 1'b1;
        frame_err_d  = (stop_sample & ~rx_s_q) | (frame_err_q & ~err_clr);
        parity_err_d = (stop_sample & rx_s_q & par_bad_q) | (parity_err_q & ~err_clr);
        overrun_d    = (good & full & ~pop) | (overrun_q & ~err_clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
        end
    end

    // Storage needs no reset; its contents are don't-care while empty.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= shift_q;
    end

    assign rx_data    = mem_q[rd_ptr_q];
    assign rx_empty   = empty;
    assign rx_full    = full;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Scoreboard bench for uart_rx. Three receivers share clock and reset:
// index 0 without parity, index 1 odd parity, index 2 even parity. Stimulus
// pushes expected bytes into a queue; a monitor pops and compares whenever a
// receiver whose auto-read is enabled presents a non-empty FIFO.
// -----------------------------------------------------------------------------
module tb_uart_rx;

    typedef struct packed {
        logic [1:0] idx;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] rx_line;
    logic [2:0] rd_en, mon_rd, man_rd, auto_rd;
    logic       err_clr;
    logic [7:0] rx_data [3];
    logic [2:0] rx_empty, rx_full, frame_err, parity_err, overrun;

    exp_t sb[$];
    int   vectors    = 0;
    int   miscompares = 0;
    int   cyc        = 0;
    int   last_t0    = -1;

    assign rd_en = mon_rd | man_rd;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx #(.SYS_CLK_FREQ(1_600_000), .BAUD_RATE(100_000), .PARITY_MODE(0), .FIFO_ADDR_BITS(3)) dut0 (
        .clk(clk), .rst(rst), .rx(rx_line[0]), .rd_en(rd_en[0]), .err_clr(err_clr),
        .rx_data(rx_data[0]), .rx_empty(rx_empty[0]), .rx_full(rx_full[0]),
        .frame_err(frame_err[0]), .parity_err(parity_err[0]), .overrun(overrun[0]));

    uart_rx #(.SYS_CLK_FREQ(1_600_000), .BAUD_RATE(100_000), .PARITY_MODE(1), .FIFO_ADDR_BITS(3)) dut1 (
        .clk(clk), .rst(rst), .rx(rx_line[1]), .rd_en(rd_en[1]), .err_clr(err_clr),
        .rx_data(rx_data[1]), .rx_empty(rx_empty[1]), .rx_full(rx_full[1]),
        .frame_err(frame_err[1]), .parity_err(parity_err[1]), .overrun(overrun[1]));

    uart_rx #(.SYS_CLK_FREQ(1_600_000), .BAUD_RATE(100_000), .PARITY_MODE(2), .FIFO_ADDR_BITS(3)) dut2 (
        .clk(clk), .rst(rst), .rx(rx_line[2]), .rd_en(rd_en[2]), .err_clr(err_clr),
        .rx_data(rx_data[2]), .rx_empty(rx_empty[2]), .rx_full(rx_full[2]),
        .frame_err(frame_err[2]), .parity_err(parity_err[2]), .overrun(overrun[2]));

    // Byte comparison, shared by stimulus and monitor.
    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", name, actual, expected);
        end
    endtask

    task automatic checkFlag(input string name, input logic actual, input logic expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
        end
    endtask

    task automatic driveBit(input int idx, input logic b);
        rx_line[idx] = b;
        repeat (16) @(negedge clk);
    endtask

    // One full frame on line idx; parity is only sent for the parity receivers.
    task automatic applyStimulus(input int idx, input logic [7:0] data, input logic par_bit, input logic stop_bit);
        @(negedge clk);
        last_t0 = cyc + 1;
        driveBit(idx, 1'b0);
        for (int i = 0; i < 8; i++) driveBit(idx, data[i]);
        if (idx != 0) driveBit(idx, par_bit);
        driveBit(idx, stop_bit);
        rx_line[idx] = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Pulse err_clr (which=0) or rd_en of receiver 0 (which=1) so that it is
    // high exactly on the stop-sample edge t0+154 of the frame being sent.
    task automatic pulseAtStopEdge(input int which);
        wait (last_t0 >= 0);
        while (cyc != last_t0 + 153) @(negedge clk);
        if (which == 0) err_clr = 1'b1;
        else            man_rd[0] = 1'b1;
        @(negedge clk);
        err_clr   = 1'b0;
        man_rd[0] = 1'b0;
    endtask

    task automatic waitDrain(input int max_cycles);
        int n = 0;
        while (sb.size() != 0 && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        checkFlag("scoreboard drained", sb.size() == 0, 1'b1);
        repeat (2) @(negedge clk);
    endtask

    // Monitor: compares the head of every auto-read receiver with the queue.
    initial begin
        mon_rd = 3'b000;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                mon_rd[i] = 1'b0;
                if (auto_rd[i] && !rx_empty[i] && !rst) begin
                    if (sb.size() == 0 || int'(sb[0].idx) != i) begin
                        vectors++;
                        miscompares++;
                        $display("[TB] FAIL unexpected byte dut%0d: got 0x%02h, expected none", i, rx_data[i]);
                    end else begin
                        checkOutput($sformatf("dut%0d rx_data", i), rx_data[i], sb[0].data);
                        void'(sb.pop_front());
                    end
                    mon_rd[i] = 1'b1;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst     = 1'b1;
        rx_line = 3'b111;
        man_rd  = 3'b000;
        auto_rd = 3'b000;
        err_clr = 1'b0;
        repeat (3) @(negedge clk);
        checkFlag("reset rx_empty", rx_empty[0], 1'b1);
        checkFlag("reset rx_full", rx_full[0], 1'b0);
        checkFlag("reset frame_err", frame_err[0], 1'b0);
        checkFlag("reset overrun", overrun[0], 1'b0);
        checkFlag("reset parity_err", parity_err[2], 1'b0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        $display("[TB] single byte 0xA5");
        sb.push_back({2'd0, 8'hA5});
        last_t0 = -1;
        fork
            applyStimulus(0, 8'hA5, 1'b0, 1'b1);
            begin
                wait (last_t0 >= 0);
                while (cyc != last_t0 + 153) @(negedge clk);
                checkFlag("empty before stop edge", rx_empty[0], 1'b1);
                @(negedge clk);
                checkFlag("empty after stop edge", rx_empty[0], 1'b0);
                checkOutput("head after stop edge", rx_data[0], 8'hA5);
            end
        join
        auto_rd[0] = 1'b1;
        waitDrain(50);
        checkFlag("empty after pop", rx_empty[0], 1'b1);

        $display("[TB] glitch rejection");
        @(negedge clk);
        rx_line[0] = 1'b0;
        repeat (4) @(negedge clk);
        rx_line[0] = 1'b1;
        repeat (40) @(negedge clk);
        checkFlag("glitch empty", rx_empty[0], 1'b1);
        checkFlag("glitch frame_err", frame_err[0], 1'b0);
        sb.push_back({2'd0, 8'h3C});
        applyStimulus(0, 8'h3C, 1'b0, 1'b1);
        waitDrain(50);

        $display("[TB] framing error");
        applyStimulus(0, 8'h55, 1'b0, 1'b0);
        checkFlag("frame_err set", frame_err[0], 1'b1);
        checkFlag("frame error empty", rx_empty[0], 1'b1);
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        checkFlag("frame_err cleared", frame_err[0], 1'b0);
        sb.push_back({2'd0, 8'h55});
        applyStimulus(0, 8'h55, 1'b0, 1'b1);
        waitDrain(50);
        checkFlag("frame_err after good byte", frame_err[0], 1'b0);

        $display("[TB] set wins over err_clr");
        last_t0 = -1;
        fork
            applyStimulus(0, 8'h55, 1'b0, 1'b0);
            pulseAtStopEdge(0);
        join
        checkFlag("frame_err set despite clr", frame_err[0], 1'b1);

        $display("[TB] fill, overrun, simultaneous push/pop");
        auto_rd[0] = 1'b0;
        for (int b = 1; b <= 8; b++) begin
            sb.push_back({2'd0, 8'(b)});
            applyStimulus(0, 8'(b), 1'b0, 1'b1);
            if (b == 7) checkFlag("full after 7 bytes", rx_full[0], 1'b0);
        end
        checkFlag("full after 8 bytes", rx_full[0], 1'b1);
        checkFlag("no overrun yet", overrun[0], 1'b0);
        applyStimulus(0, 8'h09, 1'b0, 1'b1);
        checkFlag("overrun after 9th", overrun[0], 1'b1);
        checkFlag("full after 9th", rx_full[0], 1'b1);
        checkOutput("head while full", rx_data[0], sb[0].data);
        void'(sb.pop_front());
        sb.push_back({2'd0, 8'h0A});
        last_t0 = -1;
        fork
            applyStimulus(0, 8'h0A, 1'b0, 1'b1);
            pulseAtStopEdge(1);
        join
        checkFlag("full after push+pop", rx_full[0], 1'b1);
        checkOutput("head after push+pop", rx_data[0], 8'h02);
        auto_rd[0] = 1'b1;
        waitDrain(100);
        checkFlag("empty after drain", rx_empty[0], 1'b1);

        $display("[TB] reset mid-frame");
        auto_rd[0] = 1'b0;
        applyStimulus(0, 8'h77, 1'b0, 1'b1);
        checkFlag("byte held before reset", rx_empty[0], 1'b0);
        @(negedge clk);
        driveBit(0, 1'b0);
        for (int i = 0; i < 4; i++) driveBit(0, 1'b0);
        rx_line[0] = 1'b1;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        #1;
        checkFlag("mid-frame reset empty", rx_empty[0], 1'b1);
        checkFlag("mid-frame reset full", rx_full[0], 1'b0);
        checkFlag("mid-frame reset frame_err", frame_err[0], 1'b0);
        checkFlag("mid-frame reset overrun", overrun[0], 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (80) @(negedge clk);
        checkFlag("no spurious byte after reset", rx_empty[0], 1'b1);
        auto_rd = 3'b111;
        sb.push_back({2'd0, 8'h81});
        applyStimulus(0, 8'h81, 1'b0, 1'b1);
        waitDrain(50);

        $display("[TB] even parity");
        sb.push_back({2'd2, 8'h07});
        applyStimulus(2, 8'h07, 1'b1, 1'b1);
        waitDrain(50);
        checkFlag("even good parity_err", parity_err[2], 1'b0);
        applyStimulus(2, 8'h07, 1'b0, 1'b1);
        checkFlag("even bad parity_err", parity_err[2], 1'b1);
        checkFlag("even bad empty", rx_empty[2], 1'b1);

        $display("[TB] odd parity");
        sb.push_back({2'd1, 8'h07});
        applyStimulus(1, 8'h07, 1'b0, 1'b1);
        waitDrain(50);
        checkFlag("odd good parity_err", parity_err[1], 1'b0);
        applyStimulus(1, 8'h07, 1'b1, 1'b1);
        checkFlag("odd bad parity_err", parity_err[1], 1'b1);
        checkFlag("odd bad empty", rx_empty[1], 1'b1);

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
